// File: rtl/pu_msp430_dbg_brk_ctrl_pkg.sv
// Shared types and constants for the debug breakpoint controller:
// FSM state encoding, halt-cause bit positions and the unit limit.
package pu_msp430_dbg_brk_pkg;

  localparam int MAX_BRK = 4;
  localparam int DBG_DW  = 16;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_HALTED   = 2'd2,
    ST_STEP     = 2'd3
  } brk_state_e;

  // Cause vector holds one bit per unit, then the command bit, then the step bit
  function automatic int cause_cmd(input int num_brk);
    return num_brk;
  endfunction

  function automatic int cause_step(input int num_brk);
    return num_brk + 1;
  endfunction

endpackage

// File: rtl/pu_msp430_dbg_brk_ctrl_if.sv
// Debug register port between the debug command interface and the
// breakpoint controller: register select, read/write strobes and read data.
interface pu_msp430_dbg_brk_ctrl_if;
  import pu_msp430_dbg_brk_pkg::*;

  logic [SEL_W-1:0]  dbg_sel;
  logic              dbg_rd;
  logic              dbg_wr;
  logic [DBG_DW-1:0] dbg_dout;

  modport master (output dbg_sel, output dbg_rd, output dbg_wr, input dbg_dout);
  modport slave  (input dbg_sel, input dbg_rd, input dbg_wr, output dbg_dout);
endinterface

// File: rtl/pu_msp430_dbg_brk_ctrl_regsel.sv
// Combinational debug register decode: per-unit read/write selects and the
// OR of every unit's (already self-gated) read data.
module pu_msp430_dbg_brk_regsel
  import pu_msp430_dbg_brk_pkg::*;
#(
  parameter int NUM_BRK = 4
) (
  input  logic [SEL_W-1:0]          dbg_sel,
  input  logic                      dbg_rd,
  input  logic                      dbg_wr,
  input  logic [16*NUM_BRK-1:0]     brk_dout_all,
  output logic [4*NUM_BRK-1:0]      brk_reg_rd,
  output logic [4*NUM_BRK-1:0]      brk_reg_wr,
  output logic [DBG_DW-1:0]         dbg_dout
);

  logic [3:0] reg_onehot;

  // Unit indices at or above NUM_BRK never match a loop index, so they
  // produce no strobes at all.
  always_comb begin
    brk_reg_rd = '0;
    brk_reg_wr = '0;
    dbg_dout   = '0;
    reg_onehot = 4'b0001 << dbg_sel[1:0];
    for (int u = 0; u < NUM_BRK; u++) begin
      if (dbg_sel[3:2] == u[1:0]) begin
        brk_reg_rd[4*u +: 4] = dbg_rd ? reg_onehot : 4'b0000;
        brk_reg_wr[4*u +: 4] = dbg_wr ? reg_onehot : 4'b0000;
      end
      dbg_dout = dbg_dout | brk_dout_all[16*u +: 16];
    end
  end

endmodule

// File: rtl/pu_msp430_dbg_brk_ctrl.sv
// Debug halt/run/step sequencer: merges breakpoint halt requests, records the
// halt cause, masks a re-fire on the resumed instruction, shares the register port.
module pu_msp430_dbg_brk_ctrl
  import pu_msp430_dbg_brk_pkg::*;
#(
  parameter int NUM_BRK  = 4,
  parameter int HALT_TMO = 255
) (
  input  logic                   dbg_clk,
  input  logic                   dbg_rst,
  pu_msp430_dbg_brk_ctrl_if.slave dbg_bus,
  input  logic [16*NUM_BRK-1:0]  brk_dout_all,
  input  logic [NUM_BRK-1:0]     brk_halt,
  input  logic [NUM_BRK-1:0]     brk_pnd,
  input  logic                   cmd_halt,
  input  logic                   cmd_run,
  input  logic                   cmd_step,
  input  logic                   cpu_halted,
  input  logic                   decode_noirq,
  output logic [4*NUM_BRK-1:0]   brk_reg_rd,
  output logic [4*NUM_BRK-1:0]   brk_reg_wr,
  output logic                   dbg_halt_cmd,
  output logic [NUM_BRK+1:0]     halt_cause,
  output logic                   halt_tmo,
  output logic                   step_done,
  output logic                   brk_pnd_any
);

  localparam int         C_CMD    = cause_cmd(NUM_BRK);
  localparam int         C_STEP   = cause_step(NUM_BRK);
  localparam logic [7:0] TMO_MAX  = 8'(HALT_TMO);
  localparam logic [7:0] TMO_LAST = 8'(HALT_TMO - 1);

  brk_state_e           state_q, state_d;
  logic [NUM_BRK+1:0]   cause_d;
  logic [7:0]           tmo_cnt;
  logic                 tmo_d, mask_q, mask_d, from_step_q, from_step_d, step_done_d;
  logic                 trig;
  logic [DBG_DW-1:0]    rd_data;

  pu_msp430_dbg_brk_regsel #(.NUM_BRK(NUM_BRK)) u_regsel (
    .dbg_sel      (dbg_bus.dbg_sel),
    .dbg_rd       (dbg_bus.dbg_rd),
    .dbg_wr       (dbg_bus.dbg_wr),
    .brk_dout_all (brk_dout_all),
    .brk_reg_rd   (brk_reg_rd),
    .brk_reg_wr   (brk_reg_wr),
    .dbg_dout     (rd_data)
  );

  assign dbg_bus.dbg_dout = rd_data;
  assign brk_pnd_any      = |brk_pnd;
  assign trig             = (|brk_halt) & ~mask_q;

  // cpu_halted takes priority over a run abort in HALT_REQ; the mask clears
  // after the first decode but a HALTED exit re-arms it in the same cycle.
  always_comb begin
    state_d     = state_q;
    cause_d     = halt_cause;
    tmo_d       = halt_tmo;
    mask_d      = mask_q;
    from_step_d = from_step_q;
    step_done_d = 1'b0;
    if (mask_q && decode_noirq) mask_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cmd_halt || trig) begin
          state_d = ST_HALT_REQ;
          cause_d = '0;
          if (trig) cause_d[NUM_BRK-1:0] = brk_halt;
          cause_d[C_CMD] = cmd_halt;
          from_step_d    = 1'b0;
        end
      end
      ST_HALT_REQ: begin
        if (cpu_halted) begin
          state_d     = ST_HALTED;
          step_done_d = from_step_q;
          from_step_d = 1'b0;
        end else if (cmd_run) begin
          state_d     = ST_RUN;
          cause_d     = '0;
          tmo_d       = 1'b0;
          from_step_d = 1'b0;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (cmd_step || cmd_run) begin
          state_d = cmd_step ? ST_STEP : ST_RUN;
          cause_d = '0;
          tmo_d   = 1'b0;
          mask_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (decode_noirq || cmd_halt) begin
          state_d         = ST_HALT_REQ;
          cause_d         = '0;
          cause_d[C_STEP] = decode_noirq;
          cause_d[C_CMD]  = cmd_halt;
          from_step_d     = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // dbg_halt_cmd is registered from the next state so it tracks the state register
  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      state_q      <= ST_RUN;
      halt_cause   <= '0;
      halt_tmo     <= 1'b0;
      mask_q       <= 1'b0;
      from_step_q  <= 1'b0;
      step_done    <= 1'b0;
      dbg_halt_cmd <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      halt_cause   <= cause_d;
      halt_tmo     <= tmo_d;
      mask_q       <= mask_d;
      from_step_q  <= from_step_d;
      step_done    <= step_done_d;
      dbg_halt_cmd <= (state_d == ST_HALT_REQ) || (state_d == ST_HALTED);
      if (state_q != ST_HALT_REQ)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pu_msp430_dbg_brk_ctrl.sv
// Directed bench for the debug breakpoint controller: a 4-unit instance with a
// short halt timeout plus a 3-unit instance for out-of-range select decode.
module tb_pu_msp430_dbg_brk_ctrl;

  logic        dbg_clk, dbg_rst;
  logic [63:0] brk_dout_all;
  logic [3:0]  brk_halt, brk_pnd;
  logic        cmd_halt, cmd_run, cmd_step, cpu_halted, decode_noirq;
  logic [15:0] brk_reg_rd, brk_reg_wr;
  logic        dbg_halt_cmd, halt_tmo, step_done, brk_pnd_any;
  logic [5:0]  halt_cause;

  logic [11:0] rd3, wr3;
  logic        hc3, tmo3, sd3, pa3;
  logic [4:0]  cause3;

  int total = 0;
  int bad   = 0;

  pu_msp430_dbg_brk_ctrl_if bus ();
  pu_msp430_dbg_brk_ctrl_if bus3 ();

  pu_msp430_dbg_brk_ctrl #(.NUM_BRK(4), .HALT_TMO(4)) dut (
    .dbg_clk(dbg_clk), .dbg_rst(dbg_rst), .dbg_bus(bus.slave),
    .brk_dout_all(brk_dout_all), .brk_halt(brk_halt), .brk_pnd(brk_pnd),
    .cmd_halt(cmd_halt), .cmd_run(cmd_run), .cmd_step(cmd_step),
    .cpu_halted(cpu_halted), .decode_noirq(decode_noirq),
    .brk_reg_rd(brk_reg_rd), .brk_reg_wr(brk_reg_wr), .dbg_halt_cmd(dbg_halt_cmd),
    .halt_cause(halt_cause), .halt_tmo(halt_tmo), .step_done(step_done),
    .brk_pnd_any(brk_pnd_any)
  );

  pu_msp430_dbg_brk_ctrl #(.NUM_BRK(3), .HALT_TMO(4)) dut3 (
    .dbg_clk(dbg_clk), .dbg_rst(dbg_rst), .dbg_bus(bus3.slave),
    .brk_dout_all(48'h0), .brk_halt(3'b000), .brk_pnd(3'b000),
    .cmd_halt(1'b0), .cmd_run(1'b0), .cmd_step(1'b0),
    .cpu_halted(1'b0), .decode_noirq(1'b0),
    .brk_reg_rd(rd3), .brk_reg_wr(wr3), .dbg_halt_cmd(hc3),
    .halt_cause(cause3), .halt_tmo(tmo3), .step_done(sd3),
    .brk_pnd_any(pa3)
  );

  initial dbg_clk = 1'b0;
  always #5 dbg_clk = ~dbg_clk;

  // Advance one clock and settle just after the rising edge
  task automatic cyc();
    @(posedge dbg_clk);
    #1;
  endtask

  task automatic clear_inputs();
    brk_halt = '0; brk_pnd = '0; cmd_halt = 0; cmd_run = 0; cmd_step = 0;
    decode_noirq = 0; bus.dbg_sel = '0; bus.dbg_rd = 0; bus.dbg_wr = 0;
    bus3.dbg_sel = '0; bus3.dbg_rd = 0; bus3.dbg_wr = 0;
  endtask

  task automatic test_reset();
    dbg_rst = 1; clear_inputs(); cpu_halted = 0; brk_dout_all = '0;
    cyc(); cyc();
    dbg_rst = 0;
    #1;
    total++; if (dbg_halt_cmd !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt_cmd got=%b want=0", dbg_halt_cmd); end
    total++; if (halt_cause !== 6'b0) begin bad++; $display("[TB] FAIL reset_cause got=%b want=000000", halt_cause); end
    total++; if ({halt_tmo, step_done, brk_pnd_any} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {halt_tmo, step_done, brk_pnd_any}); end
    total++; if ({brk_reg_rd, brk_reg_wr, bus.dbg_dout} !== 48'h0) begin bad++; $display("[TB] FAIL reset_regsel got=%h want=0", {brk_reg_rd, brk_reg_wr, bus.dbg_dout}); end
  endtask

  task automatic test_regsel();
    bus.dbg_sel = 4'b1001; bus.dbg_wr = 1; #1;
    total++; if (brk_reg_wr !== 16'h0200) begin bad++; $display("[TB] FAIL wr_sel9 got=%h want=0200", brk_reg_wr); end
    total++; if (brk_reg_rd !== 16'h0000) begin bad++; $display("[TB] FAIL rd_idle got=%h want=0000", brk_reg_rd); end
    bus.dbg_wr = 0; bus.dbg_sel = 4'b0011; bus.dbg_rd = 1; #1;
    total++; if ({brk_reg_rd, brk_reg_wr} !== {16'h0008, 16'h0000}) begin bad++; $display("[TB] FAIL rd_sel3 got=%h want=00080000", {brk_reg_rd, brk_reg_wr}); end
    brk_dout_all = {16'h1000, 16'h0100, 16'h0010, 16'h0001}; #1;
    total++; if (bus.dbg_dout !== 16'h1111) begin bad++; $display("[TB] FAIL dout_or got=%h want=1111", bus.dbg_dout); end
    bus.dbg_rd = 0; brk_dout_all = '0;
    bus3.dbg_sel = 4'b1101; bus3.dbg_wr = 1; bus3.dbg_rd = 1; #1;
    total++; if ({rd3, wr3} !== 24'h0) begin bad++; $display("[TB] FAIL n3_oob_strobes got=%h want=000000", {rd3, wr3}); end
    total++; if (bus3.dbg_dout !== 16'h0) begin bad++; $display("[TB] FAIL n3_oob_dout got=%h want=0000", bus3.dbg_dout); end
    bus3.dbg_sel = 4'b1001; bus3.dbg_rd = 0; #1;
    total++; if (wr3 !== 12'h200) begin bad++; $display("[TB] FAIL n3_wr_sel9 got=%h want=200", wr3); end
    bus3.dbg_wr = 0;
    brk_pnd = 4'b0010; #1;
    total++; if (brk_pnd_any !== 1'b1) begin bad++; $display("[TB] FAIL pnd_any got=%b want=1", brk_pnd_any); end
    brk_pnd = 4'b0000; #1;
    total++; if (brk_pnd_any !== 1'b0) begin bad++; $display("[TB] FAIL pnd_none got=%b want=0", brk_pnd_any); end
  endtask

  task automatic test_brk_halt();
    brk_halt = 4'b0100; cyc(); brk_halt = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== {1'b1, 6'b000100}) begin bad++; $display("[TB] FAIL brk_halt_req got=%b want=1000100", {dbg_halt_cmd, halt_cause}); end
    cyc(); cyc();
    cpu_halted = 1; cyc();
    total++; if ({dbg_halt_cmd, step_done, halt_cause} !== {2'b10, 6'b000100}) begin bad++; $display("[TB] FAIL brk_halted got=%b want=10000100", {dbg_halt_cmd, step_done, halt_cause}); end
    cyc();
    total++; if (step_done !== 1'b0) begin bad++; $display("[TB] FAIL brk_no_step_done got=%b want=0", step_done); end
  endtask

  task automatic test_resume_mask();
    cmd_run = 1; cyc(); cmd_run = 0; cpu_halted = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== 7'b0) begin bad++; $display("[TB] FAIL run_resume got=%b want=0000000", {dbg_halt_cmd, halt_cause}); end
    brk_halt = 4'b0001; decode_noirq = 1; cyc();
    brk_halt = 0; decode_noirq = 0;
    total++; if (dbg_halt_cmd !== 1'b0) begin bad++; $display("[TB] FAIL mask_suppress got=%b want=0", dbg_halt_cmd); end
    cyc();
    brk_halt = 4'b0001; decode_noirq = 1; cyc();
    brk_halt = 0; decode_noirq = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== {1'b1, 6'b000001}) begin bad++; $display("[TB] FAIL second_decode_halt got=%b want=1000001", {dbg_halt_cmd, halt_cause}); end
    cpu_halted = 1; cyc();
  endtask

  task automatic test_step();
    cmd_step = 1; cyc(); cmd_step = 0; cpu_halted = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== 7'b0) begin bad++; $display("[TB] FAIL step_enter got=%b want=0000000", {dbg_halt_cmd, halt_cause}); end
    cyc();
    total++; if (dbg_halt_cmd !== 1'b0) begin bad++; $display("[TB] FAIL step_wait got=%b want=0", dbg_halt_cmd); end
    decode_noirq = 1; cyc(); decode_noirq = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== {1'b1, 6'b100000}) begin bad++; $display("[TB] FAIL step_decode got=%b want=1100000", {dbg_halt_cmd, halt_cause}); end
    cpu_halted = 1; cyc();
    total++; if (step_done !== 1'b1) begin bad++; $display("[TB] FAIL step_done_pulse got=%b want=1", step_done); end
    cyc();
    total++; if (step_done !== 1'b0) begin bad++; $display("[TB] FAIL step_done_end got=%b want=0", step_done); end
  endtask

  task automatic test_step_cmd_halt();
    cmd_step = 1; cyc(); cmd_step = 0; cpu_halted = 0;
    cmd_halt = 1; cyc(); cmd_halt = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== {1'b1, 6'b010000}) begin bad++; $display("[TB] FAIL step_cmd_halt got=%b want=1010000", {dbg_halt_cmd, halt_cause}); end
    cpu_halted = 1; cyc();
    total++; if (step_done !== 1'b1) begin bad++; $display("[TB] FAIL step_cmd_done got=%b want=1", step_done); end
  endtask

  task automatic test_timeout();
    cmd_run = 1; cyc(); cmd_run = 0; cpu_halted = 0;
    cmd_halt = 1; cyc(); cmd_halt = 0;
    total++; if ({halt_tmo, halt_cause} !== {1'b0, 6'b010000}) begin bad++; $display("[TB] FAIL tmo_entry got=%b want=0010000", {halt_tmo, halt_cause}); end
    cyc(); cyc(); cyc();
    total++; if (halt_tmo !== 1'b0) begin bad++; $display("[TB] FAIL tmo_early got=%b want=0", halt_tmo); end
    cyc();
    total++; if (halt_tmo !== 1'b1) begin bad++; $display("[TB] FAIL tmo_set got=%b want=1", halt_tmo); end
    cyc(); cyc();
    total++; if (halt_tmo !== 1'b1) begin bad++; $display("[TB] FAIL tmo_sticky got=%b want=1", halt_tmo); end
    cmd_run = 1; cyc(); cmd_run = 0;
    total++; if ({dbg_halt_cmd, halt_tmo, halt_cause} !== 8'b0) begin bad++; $display("[TB] FAIL tmo_abort got=%b want=00000000", {dbg_halt_cmd, halt_tmo, halt_cause}); end
  endtask

  task automatic test_back_to_back();
    decode_noirq = 1; cyc(); decode_noirq = 0;
    cmd_halt = 1; brk_halt = 4'b1000; cyc(); cmd_halt = 0; brk_halt = 0;
    total++; if (halt_cause !== 6'b011000) begin bad++; $display("[TB] FAIL cmd_and_brk_cause got=%b want=011000", halt_cause); end
    cpu_halted = 1; cyc();
    cmd_run = 1; cmd_step = 1; cyc(); cmd_run = 0; cmd_step = 0; cpu_halted = 0;
    total++; if (dbg_halt_cmd !== 1'b0) begin bad++; $display("[TB] FAIL run_step_leave got=%b want=0", dbg_halt_cmd); end
    decode_noirq = 1; cyc(); decode_noirq = 0;
    total++; if ({dbg_halt_cmd, halt_cause} !== {1'b1, 6'b100000}) begin bad++; $display("[TB] FAIL step_wins got=%b want=1100000", {dbg_halt_cmd, halt_cause}); end
  endtask

  task automatic test_async_reset();
    #2 dbg_rst = 1;
    #1;
    total++; if ({dbg_halt_cmd, halt_cause, step_done} !== 8'b0) begin bad++; $display("[TB] FAIL async_reset got=%b want=00000000", {dbg_halt_cmd, halt_cause, step_done}); end
    cyc();
    dbg_rst = 0;
  endtask

  initial begin
    test_reset();
    test_regsel();
    test_brk_halt();
    test_resume_mask();
    test_step();
    test_step_cmd_halt();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pu_msp430_dbg_brk_ctrl.md
# pu_msp430_dbg_brk_ctrl

Debug-unit controller that sequences CPU halt, run and single-step, and shares the debug register port among up to four hardware break/watch-point units. It merges per-unit halt requests and records the halt cause. It also masks a breakpoint from re-firing on the instruction being resumed from, and decodes debug register selects into per-unit read/write strobes. It sits between the debug command interface and the array of hardware-breakpoint units, and drives the frontend halt request.

## Interface
- NUM_BRK, 4: number of breakpoint units attached, 1..4
- HALT_TMO, 255: cycles to wait in HALT_REQ for `cpu_halted` before flagging a timeout, 1..255
- dbg_clk  in  1  debug clock; all state on rising edge
- dbg_rst  in  1  reset, asynchronous, active-high
- dbg_sel  in  4  register select: {unit[1:0], reg[1:0]}
- dbg_rd  in  1  register read strobe
- dbg_wr  in  1  register write strobe
- brk_dout_all  in  16*NUM_BRK  concatenated per-unit read data; unit u at [16u+15:16u]
- brk_halt  in  NUM_BRK  per-unit halt request
- brk_pnd  in  NUM_BRK  per-unit pending flag
- cmd_halt  in  1  halt command pulse
- cmd_run  in  1  run command pulse
- cmd_step  in  1  single-step command pulse
- cpu_halted  in  1  frontend reports CPU stopped
- decode_noirq  in  1  frontend instruction decode strobe
- brk_reg_rd  out  4*NUM_BRK  per-unit read selects; unit u at [4u+3:4u]
- brk_reg_wr  out  4*NUM_BRK  per-unit write selects
- dbg_dout  out  16  read data
- dbg_halt_cmd  out  1  halt request to the frontend
- halt_cause  out  NUM_BRK+2  [u]=unit u, [NUM_BRK]=command, [NUM_BRK+1]=step
- halt_tmo  out  1  sticky halt-timeout flag
- step_done  out  1  one-cycle pulse when a step completes
- brk_pnd_any  out  1  OR of `brk_pnd`

## Operation
- Register select decode is combinational.
  - `brk_reg_wr[4u+r] = dbg_wr & (dbg_sel[3:2]==u) & (u<NUM_BRK)`, with `r = dbg_sel[1:0]`. `brk_reg_rd` is decoded the same way.
  - A unit index ≥ NUM_BRK produces no strobes.
  - `dbg_dout` = bitwise OR of all `brk_dout_all` slices. Each unit gates its own data by its read select.
- Trigger: `trig = |brk_halt & ~mask`.
- FSM states: RUN, HALT_REQ, HALTED, STEP. Reset state is RUN.
- RUN:
  - On `cmd_halt | trig`, go to HALT_REQ.
  - Load cause: unit bits = `brk_halt` if trig, else 0; CMD bit = `cmd_halt`.
  - `cmd_run` and `cmd_step` are ignored.
- HALT_REQ:
  - `tmo_cnt` increments from 0. When it reaches HALT_TMO, set `halt_tmo`; the counter saturates there.
  - On `cpu_halted`, go to HALTED. If entry came from STEP, pulse `step_done`.
  - `cmd_run` aborts to RUN, clears cause and `halt_tmo`, and does not set mask.
- HALTED:
  - `cmd_step` goes to STEP. Otherwise `cmd_run` goes to RUN. Step wins if both arrive together.
  - Either transition clears cause and `halt_tmo` and sets mask.
  - `cmd_halt` and `brk_halt` are ignored.
- STEP:
  - `dbg_halt_cmd` is 0.
  - On the first `decode_noirq`, go to HALT_REQ with cause = STEP only, and OR in the CMD bit if `cmd_halt` arrives in the same cycle.
  - A `cmd_halt` before that decode goes to HALT_REQ with cause = CMD.
- Mask:
  - Set on leaving HALTED.
  - Cleared in the cycle after the first `decode_noirq`. It is still 1 during that decode cycle, so a breakpoint on the resumed PC is suppressed once.
  - Cleared on reset.
- `brk_pnd_any` is combinational. Watch-only hits do not halt.

## Timing
- Reset values: state RUN, `dbg_halt_cmd` 0, `halt_cause` 0, `halt_tmo` 0, `step_done` 0, mask 0, `tmo_cnt` 0.
- `dbg_halt_cmd` is registered and equals (state==HALT_REQ | state==HALTED).
  - Trigger in cycle n gives `dbg_halt_cmd`=1 in cycle n+1.
- `cpu_halted` sampled in cycle m gives state HALTED and `step_done` in cycle m+1.
- `halt_tmo` rises exactly HALT_TMO cycles after entry into HALT_REQ if `cpu_halted` has stayed 0.
- After `cmd_step`, `dbg_halt_cmd` is low from cycle n+1 until the cycle after the first decode.
- Reset mid-sequence returns to RUN asynchronously. Outputs drop to their reset values immediately.
- `halt_cause` is registered and stable from HALT_REQ entry until the state leaves HALTED or HALT_REQ.

## Structure
- Package `pu_msp430_dbg_brk_pkg` holds:
  - state enum (2 bits);
  - cause bit offsets `CAUSE_CMD`, `CAUSE_STEP` as functions of NUM_BRK;
  - `MAX_BRK` = 4.
- Sub-module `pu_msp430_dbg_brk_regsel`: purely combinational select decode and read-data OR. The FSM, mask, counter and cause register are in the top module.

## Test plan
- Reset with all inputs 0: every output is 0 and state is RUN. Write `dbg_sel`=4'b1001 → only `brk_reg_wr[9]`=1. With NUM_BRK=3, `dbg_sel`=4'b1101 → no strobes and `dbg_dout`=0.
- `brk_halt`=4'b0100 in RUN → next cycle `dbg_halt_cmd`=1, `halt_cause`=6'b000100. `cpu_halted`=1 three cycles later → HALTED, `step_done`=0.
- In HALTED, `cmd_run` with `brk_halt[0]` asserted alongside the first `decode_noirq` → no halt. The same breakpoint on the second decode → HALT_REQ, cause bit 0.
- In HALTED, `cmd_step` → `dbg_halt_cmd`=0 next cycle. First `decode_noirq` → HALT_REQ, `halt_cause`=6'b100000. `cpu_halted` → `step_done` pulse of 1 cycle.
- HALT_TMO=4, `cmd_halt` with `cpu_halted` held 0 → `halt_tmo`=1 four cycles after HALT_REQ entry. `cmd_run` → RUN, `halt_tmo`=0, cause 0.
- In RUN, `cmd_halt` and `brk_halt[3]` in the same cycle → `halt_cause`=6'b011000. In HALTED, `cmd_run` and `cmd_step` in the same cycle → STEP.
